vga_draw_arbiter: RTL and testbench
===================================

Name: vga_draw_arbiter

Overview:
- Shares the vga_adapter framebuffer write port (x, y, colour, plot) between two drawing requesters, e.g. the card renderer and the board/background painter.
- Each request is a filled-rectangle command. The block arbitrates round-robin, then scans the rectangle one pixel per clock, driving write strobes into video memory.
- Pixels outside the COLS x ROWS screen are clipped.
- Sits between game-logic FSMs and the vga_adapter on the drawing clock domain.

Parameters:
- COLOR_DEPTH, 3: bits per pixel colour, matching the video memory.
- nX, 8: x coordinate width.
- nY, 7: y coordinate width.
- COLS, 160: screen width in pixels.
- ROWS, 120: screen height in pixels.

Ports:
- clock  in  1  drawing clock; all state updates on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 command valid; held high until ack0.
- x0_0  in  nX  requester 0 rectangle left.
- y0_0  in  nY  requester 0 rectangle top.
- w_0  in  nX  requester 0 width in pixels.
- h_0  in  nY  requester 0 height in pixels.
- col_0  in  COLOR_DEPTH  requester 0 fill colour.
- ack0  out  1  one-cycle pulse: requester 0 command accepted.
- done0  out  1  one-cycle pulse: requester 0 rectangle finished.
- req1, x0_1, y0_1, w_1, h_1, col_1, ack1, done1: same as requester 0, for requester 1.
- x  out  nX  framebuffer write x.
- y  out  nY  framebuffer write y.
- colour  out  COLOR_DEPTH  framebuffer write colour.
- plot  out  1  framebuffer write enable.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, resetn low):
  - state = IDLE; all outputs 0.
  - last_grant = 1, so requester 0 wins the first tie.
  - A reset asserted mid-draw abandons the command: no done pulse, no further plot.
- All outputs are registered.

State IDLE:
- Grant selection, sampled each cycle:
  - Only req0 high: grant 0.
  - Only req1 high: grant 1.
  - Both high: grant the requester != last_grant.
- On grant:
  - Latch x0, y0, w, h and colour of the winner.
  - Set last_grant to the winner.
  - Pulse ackN in the next cycle.
  - Go to DRAW if w != 0 and h != 0, otherwise go to DONE.
- A requester must drop reqN in the cycle after ackN is seen. reqN still high one cycle after its ack is treated as a new command.

State DRAW:
- One pixel per cycle, raster order.
- Column offset cx runs 0..w-1; row offset cy runs 0..h-1; cx wraps to 0 and cy increments when cx = w-1.
- Outputs each cycle:
  - x = x0+cx and y = y0+cy, truncated to nX/nY.
  - colour = latched colour.
  - plot = 1 only if the full-width sums (nX+1 / nY+1 bits) satisfy x0+cx < COLS and y0+cy < ROWS; otherwise plot = 0.
- A clipped pixel still consumes its cycle. DRAW therefore lasts exactly w*h cycles.
- After the cycle showing (w-1, h-1), go to DONE.

State DONE:
- One cycle: plot = 0, doneN pulses for the owning requester.
- Return to IDLE. A new grant can be made in this same IDLE cycle.

Timing and counts:
- Grant cycle to first plot: 1 cycle (ackN and first plot are coincident).
- Command throughput: w*h + 2 cycles per command including IDLE, or 3 cycles for an empty rectangle (w = 0 or h = 0).
- A request arriving during DRAW/DONE waits; it is never dropped while held.

Invariants:
- plot never high outside DRAW.
- ack0/ack1 never high in the same cycle.
- done0/done1 never high in the same cycle.

Test Plan:
- Simple fill:
  - Stimulus: req0 with (10,5), w=3, h=2, col=3'b100.
  - Required: ack0 once; 6 consecutive plot cycles at (10,5),(11,5),(12,5),(10,6),(11,6),(12,6), colour 100; then done0 one cycle later; busy high for 7 cycles.
- Empty rectangle:
  - Stimulus: req1 with w=0, h=5.
  - Required: ack1; done1 exactly one cycle later; plot never asserted.
- Round-robin:
  - Stimulus: req0 and req1 both asserted after reset with 1x1 rectangles, re-asserted continuously.
  - Required: grant order 0,1,0,1; no overlap of plot windows; each done precedes the next ack.
- Clipping:
  - Stimulus: req0 at (158,118), w=4, h=3.
  - Required: 12 DRAW cycles; plot high only at (158,118), (159,118), (158,119), (159,119); done0 after the 12th cycle.
- Reset mid-draw:
  - Stimulus: 10x10 fill; resetn low at the 20th plot cycle.
  - Required: plot, busy and the ack/done pulses go 0 immediately with no done0.
  - After release with req0 and req1 both high, requester 0 is granted first.
- Colour/position latch:
  - Stimulus: change x0_0, col_0 one cycle after ack0 during a 4x1 draw.
  - Required: all 4 pixels use the originally latched values.

Source files
------------

// File: rtl/vga_draw_arbiter.sv
// Round-robin arbiter sharing the vga_adapter write port between two
// filled-rectangle requesters; scans one pixel per clock with screen clipping.
module vga_draw_arbiter #(
    parameter int COLOR_DEPTH = 3,
    parameter int nX          = 8,
    parameter int nY          = 7,
    parameter int COLS        = 160,
    parameter int ROWS        = 120
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   req0,
    input  logic [nX-1:0]          x0_0,
    input  logic [nY-1:0]          y0_0,
    input  logic [nX-1:0]          w_0,
    input  logic [nY-1:0]          h_0,
    input  logic [COLOR_DEPTH-1:0] col_0,
    output logic                   ack0,
    output logic                   done0,
    input  logic                   req1,
    input  logic [nX-1:0]          x0_1,
    input  logic [nY-1:0]          y0_1,
    input  logic [nX-1:0]          w_1,
    input  logic [nY-1:0]          h_1,
    input  logic [COLOR_DEPTH-1:0] col_1,
    output logic                   ack1,
    output logic                   done1,
    output logic [nX-1:0]          x,
    output logic [nY-1:0]          y,
    output logic [COLOR_DEPTH-1:0] colour,
    output logic                   plot,
    output logic                   busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DRAW = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]             r_state;
    logic                   r_last;
    logic                   r_owner;
    logic [nX-1:0]          r_x0;
    logic [nY-1:0]          r_y0;
    logic [nX-1:0]          r_w;
    logic [nY-1:0]          r_h;
    logic [COLOR_DEPTH-1:0] r_col;
    logic [nX-1:0]          r_cx;
    logic [nY-1:0]          r_cy;

    logic                   w_gnt_valid;
    logic                   w_gnt;
    logic [nX-1:0]          w_sel_x0;
    logic [nY-1:0]          w_sel_y0;
    logic [nX-1:0]          w_sel_w;
    logic [nY-1:0]          w_sel_h;
    logic [COLOR_DEPTH-1:0] w_sel_col;
    logic                   w_sel_empty;
    logic                   w_row_end;
    logic                   w_last_px;
    logic [nX-1:0]          w_nx_cx;
    logic [nY-1:0]          w_nx_cy;
    logic [nX-1:0]          w_base_x;
    logic [nY-1:0]          w_base_y;
    logic [nX-1:0]          w_off_x;
    logic [nY-1:0]          w_off_y;
    logic [nX:0]            w_sum_x;
    logic [nY:0]            w_sum_y;
    logic                   w_vis;

    always_comb begin
        w_gnt_valid = req0 | req1;
        w_gnt       = (req0 && req1) ? ~r_last : req1;
        w_sel_x0    = w_gnt ? x0_1  : x0_0;
        w_sel_y0    = w_gnt ? y0_1  : y0_0;
        w_sel_w     = w_gnt ? w_1   : w_0;
        w_sel_h     = w_gnt ? h_1   : h_0;
        w_sel_col   = w_gnt ? col_1 : col_0;
        w_sel_empty = (w_sel_w == '0) || (w_sel_h == '0);

        w_row_end = (r_cx == r_w - nX'(1));
        w_last_px = w_row_end && (r_cy == r_h - nY'(1));
        w_nx_cx   = w_row_end ? '0 : r_cx + nX'(1);
        w_nx_cy   = w_row_end ? r_cy + nY'(1) : r_cy;

        // Pixel registered at the next edge: origin of the winner when granting,
        // otherwise the successor of the pixel currently on the outputs.
        w_base_x = (r_state == S_IDLE) ? w_sel_x0 : r_x0;
        w_base_y = (r_state == S_IDLE) ? w_sel_y0 : r_y0;
        w_off_x  = (r_state == S_IDLE) ? '0 : w_nx_cx;
        w_off_y  = (r_state == S_IDLE) ? '0 : w_nx_cy;
        w_sum_x  = {1'b0, w_base_x} + {1'b0, w_off_x};
        w_sum_y  = {1'b0, w_base_y} + {1'b0, w_off_y};
        w_vis    = (w_sum_x < (nX+1)'(COLS)) && (w_sum_y < (nY+1)'(ROWS));
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_owner <= 1'b0;
            r_x0    <= '0;
            r_y0    <= '0;
            r_w     <= '0;
            r_h     <= '0;
            r_col   <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            x       <= '0;
            y       <= '0;
            colour  <= '0;
            plot    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            plot  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_valid) begin
                        r_x0    <= w_sel_x0;
                        r_y0    <= w_sel_y0;
                        r_w     <= w_sel_w;
                        r_h     <= w_sel_h;
                        r_col   <= w_sel_col;
                        r_last  <= w_gnt;
                        r_owner <= w_gnt;
                        ack0    <= ~w_gnt;
                        ack1    <= w_gnt;
                        busy    <= 1'b1;
                        if (w_sel_empty) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_DRAW;
                            r_cx    <= '0;
                            r_cy    <= '0;
                            x       <= w_sum_x[nX-1:0];
                            y       <= w_sum_y[nY-1:0];
                            colour  <= w_sel_col;
                            plot    <= w_vis;
                        end
                    end
                end
                S_DRAW: begin
                    if (w_last_px) begin
                        r_state <= S_DONE;
                        done0   <= ~r_owner;
                        done1   <= r_owner;
                    end else begin
                        r_cx <= w_nx_cx;
                        r_cy <= w_nx_cy;
                        x    <= w_sum_x[nX-1:0];
                        y    <= w_sum_y[nY-1:0];
                        plot <= w_vis;
                    end
                end
                S_DONE: begin
                    // Ack still showing means an empty rectangle just arrived:
                    // hold one more cycle so done follows ack by one cycle.
                    if (ack0 || ack1) begin
                        done0 <= ~r_owner;
                        done1 <= r_owner;
                    end else begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Directed self-checking bench for vga_draw_arbiter.
module tb_vga_draw_arbiter;

    logic       clock;
    logic       resetn;
    logic       req0, req1;
    logic [7:0] x0_0, x0_1, w_0, w_1;
    logic [6:0] y0_0, y0_1, h_0, h_1;
    logic [2:0] col_0, col_1;
    logic       ack0, ack1, done0, done1;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy;

    int n_checks = 0;
    int n_errors = 0;

    vga_draw_arbiter #(
        .COLOR_DEPTH(3),
        .nX(8),
        .nY(7),
        .COLS(160),
        .ROWS(120)
    ) dut (
        .clock(clock), .resetn(resetn),
        .req0(req0), .x0_0(x0_0), .y0_0(y0_0), .w_0(w_0), .h_0(h_0), .col_0(col_0),
        .ack0(ack0), .done0(done0),
        .req1(req1), .x0_1(x0_1), .y0_1(y0_1), .w_1(w_1), .h_1(h_1), .col_1(col_1),
        .ack1(ack1), .done1(done1),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (resetn) begin
            check("inv_ack",  32'(ack0 & ack1), 32'd0);
            check("inv_done", 32'(done0 & done1), 32'd0);
            check("inv_plot", 32'(plot & ~busy), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] clip_exp;
        int ph, own;
        clip_exp = 12'b0000_0011_0011;
        resetn = 1'b0;
        req0 = 1'b0; x0_0 = '0; y0_0 = '0; w_0 = '0; h_0 = '0; col_0 = '0;
        req1 = 1'b0; x0_1 = '0; y0_1 = '0; w_1 = '0; h_1 = '0; col_1 = '0;
        repeat (3) @(negedge clock);
        check("rst_pulses", {ack0, ack1, done0, done1, plot}, 5'b00000);
        check("rst_busy", busy, 1'b0);
        check("rst_xy", {x, y, colour}, 18'd0);
        resetn = 1'b1;
        @(negedge clock);

        // Simple fill 3x2 at (10,5)
        req0 = 1'b1; x0_0 = 8'd10; y0_0 = 7'd5; w_0 = 8'd3; h_0 = 7'd2; col_0 = 3'b100;
        @(negedge clock);
        check("fill_ack", {ack0, ack1}, 2'b10);
        req0 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                @(negedge clock);
                check("fill_ack_once", {ack0, ack1}, 2'b00);
            end
            check("fill_plot", plot, 1'b1);
            check("fill_x", x, 10 + i % 3);
            check("fill_y", y, 5 + i / 3);
            check("fill_col", colour, 3'b100);
            check("fill_busy", busy, 1'b1);
        end
        @(negedge clock);
        check("fill_done", {done0, done1, plot, busy}, 4'b1001);
        @(negedge clock);
        check("fill_idle", {done0, done1, plot, busy}, 4'b0000);

        // Empty rectangle on requester 1
        req1 = 1'b1; x0_1 = 8'd3; y0_1 = 7'd3; w_1 = 8'd0; h_1 = 7'd5; col_1 = 3'd7;
        @(negedge clock);
        check("empty_ack", {ack0, ack1, done0, done1, plot, busy}, 6'b010001);
        req1 = 1'b0;
        @(negedge clock);
        check("empty_done", {ack0, ack1, done0, done1, plot, busy}, 6'b000101);
        @(negedge clock);
        check("empty_idle", {ack0, ack1, done0, done1, plot, busy}, 6'b000000);

        // Round-robin with both held, 1x1 rectangles
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        req0 = 1'b1; x0_0 = 8'd1; y0_0 = 7'd1; w_0 = 8'd1; h_0 = 7'd1; col_0 = 3'd1;
        req1 = 1'b1; x0_1 = 8'd2; y0_1 = 7'd2; w_1 = 8'd1; h_1 = 7'd1; col_1 = 3'd2;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            ph  = (k - 1) % 3;
            own = ((k - 1) / 3) % 2;
            if (ph == 0) begin
                check("rr_ack", {ack0, ack1, done0, done1, plot}, (own != 0) ? 5'b01001 : 5'b10001);
                check("rr_x", x, (own != 0) ? 8'd2 : 8'd1);
            end else if (ph == 1) begin
                check("rr_done", {ack0, ack1, done0, done1, plot}, (own != 0) ? 5'b00010 : 5'b00100);
            end else begin
                check("rr_gap", {ack0, ack1, done0, done1, plot}, 5'b00000);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clock);
        check("rr_drain", busy, 1'b0);

        // Clipping at the bottom-right corner
        req0 = 1'b1; x0_0 = 8'd158; y0_0 = 7'd118; w_0 = 8'd4; h_0 = 7'd3; col_0 = 3'd5;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            req0 = 1'b0;
            check("clip_x", x, 158 + i % 4);
            check("clip_y", y, 118 + i / 4);
            check("clip_plot", plot, clip_exp[i]);
            check("clip_nodone", done0, 1'b0);
        end
        @(negedge clock);
        check("clip_done", {done0, plot, busy}, 3'b101);
        @(negedge clock);

        // Latched position and colour survive input changes
        req0 = 1'b1; x0_0 = 8'd20; y0_0 = 7'd30; w_0 = 8'd4; h_0 = 7'd1; col_0 = 3'd2;
        @(negedge clock);
        check("latch_ack", ack0, 1'b1);
        req0 = 1'b0; x0_0 = 8'd50; col_0 = 3'd5;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clock);
            check("latch_px", {plot, x, y, colour}, {1'b1, 8'(20 + i), 7'd30, 3'd2});
        end
        @(negedge clock);
        check("latch_done", done0, 1'b1);
        @(negedge clock);

        // Reset in the middle of a 10x10 fill
        req0 = 1'b1; x0_0 = 8'd0; y0_0 = 7'd0; w_0 = 8'd10; h_0 = 7'd10; col_0 = 3'd1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            req0 = 1'b0;
        end
        check("mid_px20", {plot, x, y}, {1'b1, 8'd9, 7'd1});
        resetn = 1'b0;
        #1;
        check("mid_rst", {plot, busy, ack0, ack1, done0, done1}, 6'b000000);
        @(negedge clock);
        check("mid_nodone", {plot, busy, done0}, 3'b000);
        resetn = 1'b1;
        req0 = 1'b1; x0_0 = 8'd4; y0_0 = 7'd4; w_0 = 8'd1; h_0 = 7'd1;
        req1 = 1'b1; x0_1 = 8'd6; y0_1 = 7'd6; w_1 = 8'd1; h_1 = 7'd1;
        @(negedge clock);
        check("mid_first_grant", {ack0, ack1}, 2'b10);
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(negedge clock);
        check("end_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
